// File: rtl/filter_sched_pkg.sv
// filter_sched_pkg: shared types, defaults and helpers for filter_scheduler.
package filter_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam int unsigned CH_DEF    = 4;
   localparam int unsigned CNT_W_DEF = 3;

   // A threshold of zero would accept every glitch, so it is treated as one.
   function automatic logic [15:0] thr_fixup(input logic [15:0] thr);
      return (thr == 16'd0) ? 16'd1 : thr;
   endfunction

endpackage

// File: rtl/filter_core.sv
// filter_core: combinational single-channel consecutive-sample filter update.
module filter_core #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             s_bit_i,
   input  logic             level_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [CNT_W-1:0] thr_i,
   output logic             level_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             toggle_o
);

   logic [CNT_W:0] run;

   // Count differing samples; flip the level once the run reaches the threshold
   always_comb begin
      level_o  = level_i;
      cnt_o    = '0;
      toggle_o = 1'b0;
      run      = {1'b0, cnt_i} + (CNT_W+1)'(1);
      if (s_bit_i != level_i) begin
         if (run >= {1'b0, thr_i}) begin
            level_o  = s_bit_i;
            toggle_o = 1'b1;
         end else begin
            cnt_o = cnt_i + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/filter_scheduler.sv
// filter_scheduler: round-robin glitch filter for CH lines sharing one filter_core.
// Optional sticky change flags (chg_flag/chg_clr) when FILTER_SCHED_IRQ_EN is defined.
module filter_scheduler
   import filter_sched_pkg::*;
#(
   parameter  int unsigned CH    = CH_DEF,
   parameter  int unsigned CNT_W = CNT_W_DEF,
   localparam int unsigned PTR_W = $clog2(CH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CH-1:0]    sig_in,
   input  logic             enable,
   input  logic [CNT_W-1:0] thresh,
   output logic [CH-1:0]    sig_out,
   output logic [PTR_W-1:0] ch_sel,
   output logic             busy
`ifdef FILTER_SCHED_IRQ_EN
   ,
   output logic [CH-1:0]    chg_flag,
   input  logic [CH-1:0]    chg_clr
`endif
);

   state_e           state_q, state_d;
   logic [CH-1:0]    s_meta_q, s_in_q;
   logic [CH-1:0]    sig_out_q, sig_out_d;
   logic [CNT_W-1:0] cnt_q [CH];
   logic [CNT_W-1:0] cnt_d [CH];
   logic [PTR_W-1:0] ch_sel_q, ch_sel_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] thr_q, thr_d;

   logic             core_level, core_toggle;
   logic [CNT_W-1:0] core_cnt;

   // Two-flop synchronizer on every raw input, running in all states
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s_meta_q <= '0;
         s_in_q   <= '0;
      end else begin
         s_meta_q <= sig_in;
         s_in_q   <= s_meta_q;
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: scan while enable is high
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (enable)  state_d = SCAN;
         SCAN: if (!enable) state_d = IDLE;
      endcase
   end

   // FSM outputs: pointer advance, busy, threshold capture on scan start
   always_comb begin
      ch_sel_d = '0;
      busy_d   = (state_d == SCAN);
      thr_d    = thr_q;
      if (state_q == IDLE && state_d == SCAN) begin
         thr_d = CNT_W'(thr_fixup(16'(thresh)));
      end
      if (state_q == SCAN && state_d == SCAN) begin
         ch_sel_d = (ch_sel_q == PTR_W'(CH-1)) ? '0 : ch_sel_q + PTR_W'(1);
      end
   end

   filter_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .s_bit_i  (s_in_q[ch_sel_q]),
      .level_i  (sig_out_q[ch_sel_q]),
      .cnt_i    (cnt_q[ch_sel_q]),
      .thr_i    (thr_q),
      .level_o  (core_level),
      .cnt_o    (core_cnt),
      .toggle_o (core_toggle)
   );

   // Write the shared engine's result back to the serviced channel only;
   // the final slot on the SCAN->IDLE edge still completes
   always_comb begin
      sig_out_d = sig_out_q;
      for (int unsigned i = 0; i < CH; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (state_q == SCAN) begin
         sig_out_d[ch_sel_q] = core_level;
         cnt_d[ch_sel_q]     = core_cnt;
      end
   end

   // Per-channel level/count storage, pointer, busy and threshold registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sig_out_q <= '0;
         ch_sel_q  <= '0;
         busy_q    <= 1'b0;
         thr_q     <= CNT_W'(1);
         for (int unsigned i = 0; i < CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sig_out_q <= sig_out_d;
         ch_sel_q  <= ch_sel_d;
         busy_q    <= busy_d;
         thr_q     <= thr_d;
         for (int unsigned i = 0; i < CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sig_out = sig_out_q;
   assign ch_sel  = ch_sel_q;
   assign busy    = busy_q;

`ifdef FILTER_SCHED_IRQ_EN
   logic [CH-1:0] chg_set, chg_flag_q, chg_flag_d;

   // Sticky flags: a toggle sets, a clear strobe resets, set wins a tie
   always_comb begin
      chg_set = '0;
      if (state_q == SCAN) begin
         chg_set[ch_sel_q] = core_toggle;
      end
      chg_flag_d = chg_set | (chg_flag_q & ~chg_clr);
   end

   // Change flag register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chg_flag_q <= '0;
      end else begin
         chg_flag_q <= chg_flag_d;
      end
   end

   assign chg_flag = chg_flag_q;
`else
   // The toggle strobe only feeds the change flags
   logic unused_toggle;
   assign unused_toggle = core_toggle;
`endif

endmodule

// File: tb/tb_filter_scheduler.sv
// tb_filter_scheduler: randomized and directed checks of filter_scheduler (CH=4, CNT_W=3)
// against a behavioural model. Define FILTER_SCHED_IRQ_EN to also cover change flags.
module tb_filter_scheduler;

   localparam int CH    = 4;
   localparam int CNT_W = 3;
   localparam int PTR_W = 2;

   logic             clock  = 1'b0;
   logic             reset  = 1'b0;
   logic             enable = 1'b0;
   logic [CH-1:0]    sig_in = '0;
   logic [CNT_W-1:0] thresh = '0;
   logic [CH-1:0]    sig_out;
   logic [PTR_W-1:0] ch_sel;
   logic             busy;
`ifdef FILTER_SCHED_IRQ_EN
   logic [CH-1:0]    chg_flag;
   logic [CH-1:0]    chg_clr = '0;
`endif

   int compared   = 0;
   int mismatched = 0;

   filter_scheduler #(
      .CH    (CH),
      .CNT_W (CNT_W)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .sig_in  (sig_in),
      .enable  (enable),
      .thresh  (thresh),
      .sig_out (sig_out),
      .ch_sel  (ch_sel),
      .busy    (busy)
`ifdef FILTER_SCHED_IRQ_EN
      ,
      .chg_flag (chg_flag),
      .chg_clr  (chg_clr)
`endif
   );

   always #5 clock = ~clock;

   // Behavioural model: each line is seen two clocks late; while scanning, one channel
   // per clock (taken in turn) counts how many of its services in a row saw a level
   // other than its output, and adopts the new level once that run reaches the threshold.
   int m_meta [CH] = '{default: 0};
   int m_sync [CH] = '{default: 0};
   int m_out  [CH] = '{default: 0};
   int m_run  [CH] = '{default: 0};
   int m_flag [CH] = '{default: 0};
   int m_scan = 0;
   int m_ptr  = 0;
   int m_thr  = 1;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CH; i++) begin
            m_meta[i] = 0; m_sync[i] = 0; m_out[i] = 0; m_run[i] = 0; m_flag[i] = 0;
         end
         m_scan = 0; m_ptr = 0; m_thr = 1;
      end else begin
         int tog;
         tog = -1;
         if (m_scan != 0) begin
            if (m_sync[m_ptr] == m_out[m_ptr]) begin
               m_run[m_ptr] = 0;
            end else if (m_run[m_ptr] + 1 >= m_thr) begin
               m_out[m_ptr] = m_sync[m_ptr];
               m_run[m_ptr] = 0;
               tog = m_ptr;
            end else begin
               m_run[m_ptr] = m_run[m_ptr] + 1;
            end
            if (enable) m_ptr = (m_ptr + 1) % CH;
            else begin m_scan = 0; m_ptr = 0; end
         end else if (enable) begin
            m_scan = 1;
            m_thr  = (thresh == 0) ? 1 : int'(thresh);
         end
         for (int i = 0; i < CH; i++) begin
`ifdef FILTER_SCHED_IRQ_EN
            if (i == tog) m_flag[i] = 1;
            else if (chg_clr[i]) m_flag[i] = 0;
`endif
            m_sync[i] = m_meta[i];
            m_meta[i] = sig_in[i] ? 1 : 0;
         end
      end
   end

   function automatic logic [CH-1:0] exp_out();
      logic [CH-1:0] r;
      for (int i = 0; i < CH; i++) r[i] = (m_out[i] != 0);
      return r;
   endfunction

   function automatic logic [CH-1:0] exp_flag();
      logic [CH-1:0] r;
      for (int i = 0; i < CH; i++) r[i] = (m_flag[i] != 0);
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; sig_in = '0; thresh = '0;
      @(negedge clock); @(negedge clock);
      compared++; if (sig_out !== '0) begin mismatched++; $display("FAIL reset_sig_out got %b want 0000", sig_out); end
      compared++; if (ch_sel !== '0) begin mismatched++; $display("FAIL reset_ch_sel got %0d want 0", ch_sel); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
      reset = 1'b1;
      tick();
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_propagation();
      int seen;
      seen = -1;
      thresh = 3'd3; sig_in = 4'b0001; enable = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         compared++; if (sig_out !== exp_out()) begin mismatched++; $display("FAIL prop_sig_out cyc %0d got %b want %b", k, sig_out, exp_out()); end
         compared++; if (ch_sel !== PTR_W'(m_ptr)) begin mismatched++; $display("FAIL prop_ch_sel cyc %0d got %0d want %0d", k, ch_sel, m_ptr); end
         compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL prop_busy cyc %0d got %b want 1", k, busy); end
         compared++; if (sig_out[3:1] !== 3'b000) begin mismatched++; $display("FAIL prop_quiet cyc %0d got %b want 000", k, sig_out[3:1]); end
         if (sig_out[0] === 1'b1 && seen < 0) seen = k;
      end
      compared++;
      if (seen < 0 || seen > 2 + CH * 3) begin
         mismatched++; $display("FAIL prop_latency got %0d cycles want <= %0d", seen, 2 + CH * 3);
      end
   endtask

   task automatic test_glitch();
      sig_in[1] = 1'b1;
      for (int k = 0; k < 26; k++) begin
         if (k == 6) sig_in[1] = 1'b0;
         tick();
         compared++; if (sig_out[1] !== 1'b0) begin mismatched++; $display("FAIL glitch_out1 cyc %0d got %b want 0", k, sig_out[1]); end
         compared++; if (sig_out !== exp_out()) begin mismatched++; $display("FAIL glitch_sig_out cyc %0d got %b want %b", k, sig_out, exp_out()); end
      end
   endtask

   task automatic test_pause_resume();
      int k;
      sig_in[2] = 1'b1;
      k = 0;
      while (m_run[2] != 2 && k < 40) begin
         tick(); k++;
         compared++; if (sig_out !== exp_out()) begin mismatched++; $display("FAIL pause_sig_out cyc %0d got %b want %b", k, sig_out, exp_out()); end
      end
      compared++; if (m_run[2] != 2) begin mismatched++; $display("FAIL pause_setup timeout after %0d cycles want run 2", k); end
      enable = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick();
         compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL pause_busy idle %0d got %b want 0", j, busy); end
         compared++; if (ch_sel !== '0) begin mismatched++; $display("FAIL pause_ch_sel idle %0d got %0d want 0", j, ch_sel); end
         compared++; if (sig_out[2] !== 1'b0) begin mismatched++; $display("FAIL pause_out2 idle %0d got %b want 0", j, sig_out[2]); end
      end
      thresh = 3'd3; enable = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         tick();
         compared++;
         if (sig_out[2] !== ((j == 4) ? 1'b1 : 1'b0)) begin
            mismatched++; $display("FAIL resume_out2 cyc %0d got %b want %b", j, sig_out[2], (j == 4));
         end
      end
   endtask

   task automatic test_thresh_zero();
      int seen;
      enable = 1'b0;
      tick();
      thresh = 3'd0; enable = 1'b1;
      tick(); tick(); tick();
      sig_in[3] = ~sig_in[3];
      seen = -1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         compared++; if (sig_out !== exp_out()) begin mismatched++; $display("FAIL thr0_sig_out cyc %0d got %b want %b", k, sig_out, exp_out()); end
         if (sig_out[3] === sig_in[3] && seen < 0) seen = k;
      end
      compared++;
      if (seen < 0 || seen > 2 + CH) begin
         mismatched++; $display("FAIL thr0_latency got %0d cycles want <= %0d", seen, 2 + CH);
      end
   endtask

   task automatic test_reset_midscan();
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      compared++; if (sig_out !== '0) begin mismatched++; $display("FAIL areset_sig_out got %b want 0000", sig_out); end
      compared++; if (ch_sel !== '0) begin mismatched++; $display("FAIL areset_ch_sel got %0d want 0", ch_sel); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL areset_busy got %b want 0", busy); end
      @(negedge clock);
      reset = 1'b1; enable = 1'b1;
      tick();
      compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL restart_busy got %b want 1", busy); end
      compared++; if (ch_sel !== 2'd0) begin mismatched++; $display("FAIL restart_ch_sel0 got %0d want 0", ch_sel); end
      tick();
      compared++; if (ch_sel !== 2'd1) begin mismatched++; $display("FAIL restart_ch_sel1 got %0d want 1", ch_sel); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         if (enable ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0)) enable = ~enable;
         thresh = CNT_W'($urandom);
         for (int i = 0; i < CH; i++) if ($urandom_range(0, 11) == 0) sig_in[i] = ~sig_in[i];
`ifdef FILTER_SCHED_IRQ_EN
         chg_clr = CH'($urandom) & CH'($urandom);
`endif
         tick();
         compared++; if (sig_out !== exp_out()) begin mismatched++; $display("FAIL rand_sig_out cyc %0d got %b want %b", k, sig_out, exp_out()); end
         compared++; if (ch_sel !== PTR_W'(m_ptr)) begin mismatched++; $display("FAIL rand_ch_sel cyc %0d got %0d want %0d", k, ch_sel, m_ptr); end
         compared++; if (busy !== (m_scan != 0)) begin mismatched++; $display("FAIL rand_busy cyc %0d got %b want %b", k, busy, (m_scan != 0)); end
`ifdef FILTER_SCHED_IRQ_EN
         compared++; if (chg_flag !== exp_flag()) begin mismatched++; $display("FAIL rand_chg_flag cyc %0d got %b want %b", k, chg_flag, exp_flag()); end
`endif
      end
`ifdef FILTER_SCHED_IRQ_EN
      chg_clr = '0;
`endif
   endtask

`ifdef FILTER_SCHED_IRQ_EN
   task automatic test_irq();
      int k;
      logic before;
      enable = 1'b1; chg_clr = 4'b1111;
      tick(); tick();
      chg_clr = '0;
      before = sig_out[3];
      sig_in[3] = ~before;
      k = 0;
      while (sig_out[3] === before && k < 60) begin tick(); k++; end
      compared++; if (chg_flag[3] !== 1'b1) begin mismatched++; $display("FAIL irq_set got %b want 1", chg_flag[3]); end
      chg_clr[3] = 1'b1;
      tick();
      chg_clr[3] = 1'b0;
      compared++; if (chg_flag[3] !== 1'b0) begin mismatched++; $display("FAIL irq_clear got %b want 0", chg_flag[3]); end
      chg_clr[3] = 1'b1;
      before = sig_out[3];
      sig_in[3] = ~before;
      k = 0;
      while (sig_out[3] === before && k < 60) begin
         tick(); k++;
         if (sig_out[3] === before) begin
            compared++; if (chg_flag[3] !== 1'b0) begin mismatched++; $display("FAIL irq_held_clear got %b want 0", chg_flag[3]); end
         end
      end
      compared++; if (chg_flag[3] !== 1'b1) begin mismatched++; $display("FAIL irq_set_wins got %b want 1", chg_flag[3]); end
      compared++; if (chg_flag !== exp_flag()) begin mismatched++; $display("FAIL irq_model got %b want %b", chg_flag, exp_flag()); end
      chg_clr = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_propagation();
      test_glitch();
      test_pause_resume();
      test_thresh_zero();
      test_reset_midscan();
`ifdef FILTER_SCHED_IRQ_EN
      test_irq();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
